// File: rtl/cam_lru_flush_if.sv
// Bus bundle for cam_lru_flush: request/response signals named from the CAM's side.
// slave = the CAM, master = the requester driving operations.
interface cam_lru_flush_if #(
    parameter int key_width_p = 8,
    parameter int val_width_p = 32,
    parameter int camsize_p   = 8
);
    localparam int idx_w = $clog2(camsize_p);

    logic                   ready_o;
    logic                   w_v_i;
    logic [key_width_p-1:0] w_key_i;
    logic [val_width_p-1:0] w_data_i;
    logic                   r_v_i;
    logic [key_width_p-1:0] r_key_i;
    logic                   inv_v_i;
    logic                   flush_i;
    logic [val_width_p-1:0] rdata_o;
    logic                   valid_o;
    logic [idx_w-1:0]       rindex_o;
    logic                   wdone_o;
    logic [idx_w-1:0]       windex_o;
    logic                   evict_o;
    logic [key_width_p-1:0] evict_key_o;
    logic [idx_w:0]         occupancy_o;
    logic [31:0]            hit_count_o;
    logic [31:0]            evict_count_o;

    modport slave (
        output ready_o, rdata_o, valid_o, rindex_o, wdone_o, windex_o,
               evict_o, evict_key_o, occupancy_o, hit_count_o, evict_count_o,
        input  w_v_i, w_key_i, w_data_i, r_v_i, r_key_i, inv_v_i, flush_i
    );

    modport master (
        input  ready_o, rdata_o, valid_o, rindex_o, wdone_o, windex_o,
               evict_o, evict_key_o, occupancy_o, hit_count_o, evict_count_o,
        output w_v_i, w_key_i, w_data_i, r_v_i, r_key_i, inv_v_i, flush_i
    );
endinterface

// File: rtl/cam_lru_flush.sv
// Fully-associative CAM, true-LRU replacement, key invalidate and one-entry-per-cycle flush.
// Define CAM_STATS_EN to build the saturating hit/eviction counters.
module cam_lru_flush #(
    parameter int key_width_p = 8,
    parameter int val_width_p = 32,
    parameter int camsize_p   = 8
) (
    input logic          clk_i,
    input logic          rst_ni,
    cam_lru_flush_if.slave bus
);
    localparam int idx_w = $clog2(camsize_p);
    typedef logic [idx_w-1:0] idx_t;
    typedef logic [idx_w:0] occ_t;
    typedef logic [camsize_p-1:0][idx_w-1:0] ages_t;
    typedef enum logic {IDLE, FLUSH} state_e;

    localparam idx_t LAST = idx_t'(camsize_p - 1);

    state_e state_q, state_d;
    idx_t   fl_idx_q, fl_idx_d;

    logic [camsize_p-1:0]                  valid_q, valid_d;
    logic [camsize_p-1:0][key_width_p-1:0] key_q, key_d;
    logic [camsize_p-1:0][val_width_p-1:0] val_q, val_d;
    ages_t                                 age_q, age_d;

    logic r_hit, w_hit, free_ok, rd, wr, inv, evict;
    idx_t r_idx, w_hidx, free_idx, lru_idx, w_idx;
    occ_t occ_d, occ_q;

    logic                   rvalid_q, wdone_q, evict_q;
    logic [val_width_p-1:0] rdata_q;
    idx_t                   rindex_q, windex_q;
    logic [key_width_p-1:0] evict_key_q;

    // Entry t becomes MRU; everything younger than its old age ages by one.
    function automatic ages_t touch(input ages_t a, input idx_t t);
        touch = a;
        for (int i = 0; i < camsize_p; i++) begin
            if (idx_t'(i) == t) touch[i] = '0;
            else if (a[i] < a[t]) touch[i] = a[i] + idx_t'(1);
        end
    endfunction

    always_comb begin
        r_hit = 1'b0; r_idx = '0; w_hit = 1'b0; w_hidx = '0;
        free_ok = 1'b0; free_idx = '0; lru_idx = '0;
        // Descending scan so the lowest free index wins.
        for (int i = camsize_p - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == bus.r_key_i) begin r_hit = 1'b1; r_idx = idx_t'(i); end
            if (valid_q[i] && key_q[i] == bus.w_key_i) begin w_hit = 1'b1; w_hidx = idx_t'(i); end
            if (!valid_q[i]) begin free_ok = 1'b1; free_idx = idx_t'(i); end
            if (age_q[i] == LAST) lru_idx = idx_t'(i);
        end
    end

    assign rd    = (state_q == IDLE) && bus.r_v_i;
    assign wr    = (state_q == IDLE) && bus.w_v_i;
    assign inv   = (state_q == IDLE) && bus.inv_v_i && r_hit;
    assign w_idx = w_hit ? w_hidx : (free_ok ? free_idx : lru_idx);
    assign evict = wr && !w_hit && !free_ok;

    always_comb begin
        state_d  = state_q;
        fl_idx_d = fl_idx_q;
        if (state_q == IDLE) begin
            if (bus.flush_i) begin
                state_d  = FLUSH;
                fl_idx_d = '0;
            end
        end else begin
            fl_idx_d = fl_idx_q + idx_t'(1);
            if (fl_idx_q == LAST) state_d = IDLE;
        end
    end

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        val_d   = val_q;
        age_d   = age_q;
        if (state_q == FLUSH) begin
            valid_d[fl_idx_q] = 1'b0;
            if (fl_idx_q == LAST)
                for (int i = 0; i < camsize_p; i++) age_d[i] = idx_t'(i);
        end else begin
            // Read touch first so a same-cycle write leaves its entry as MRU.
            if (rd && r_hit) age_d = touch(age_d, r_idx);
            if (wr) age_d = touch(age_d, w_idx);
            if (inv) valid_d[r_idx] = 1'b0;
            if (wr) begin
                valid_d[w_idx] = 1'b1;
                key_d[w_idx]   = bus.w_key_i;
                val_d[w_idx]   = bus.w_data_i;
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < camsize_p; i++) occ_d = occ_d + occ_t'(valid_d[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            fl_idx_q    <= '0;
            valid_q     <= '0;
            key_q       <= '0;
            val_q       <= '0;
            for (int i = 0; i < camsize_p; i++) age_q[i] <= idx_t'(i);
            occ_q       <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rindex_q    <= '0;
            wdone_q     <= 1'b0;
            windex_q    <= '0;
            evict_q     <= 1'b0;
            evict_key_q <= '0;
        end else begin
            state_q     <= state_d;
            fl_idx_q    <= fl_idx_d;
            valid_q     <= valid_d;
            key_q       <= key_d;
            val_q       <= val_d;
            age_q       <= age_d;
            occ_q       <= occ_d;
            rvalid_q    <= rd && r_hit;
            rdata_q     <= (rd && r_hit) ? val_q[r_idx] : '0;
            rindex_q    <= (rd && r_hit) ? r_idx : '0;
            wdone_q     <= wr;
            windex_q    <= wr ? w_idx : '0;
            evict_q     <= evict;
            evict_key_q <= evict ? key_q[lru_idx] : '0;
        end
    end

    assign bus.ready_o     = (state_q == IDLE);
    assign bus.valid_o     = rvalid_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.rindex_o    = rindex_q;
    assign bus.wdone_o     = wdone_q;
    assign bus.windex_o    = windex_q;
    assign bus.evict_o     = evict_q;
    assign bus.evict_key_o = evict_key_q;
    assign bus.occupancy_o = occ_q;

`ifdef CAM_STATS_EN
    logic [31:0] hit_cnt_q, ev_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q <= '0;
            ev_cnt_q  <= '0;
        end else begin
            if (rd && r_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (evict && ev_cnt_q != '1) ev_cnt_q <= ev_cnt_q + 32'd1;
        end
    end

    assign bus.hit_count_o   = hit_cnt_q;
    assign bus.evict_count_o = ev_cnt_q;
`else
    assign bus.hit_count_o   = '0;
    assign bus.evict_count_o = '0;
`endif
endmodule

// File: tb/tb_cam_lru_flush.sv
// Scoreboard bench for cam_lru_flush (camsize 4): queue-based LRU reference model,
// directed scenarios followed by random traffic; a negedge monitor checks responses.
module tb_cam_lru_flush;
    localparam int KW = 8;
    localparam int VW = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct { logic [VW-1:0] data; logic [IW-1:0] idx; } rd_exp_t;
    typedef struct { logic [IW-1:0] idx; logic ev; logic [KW-1:0] ekey; } wr_exp_t;
    typedef struct { logic rdy; logic [IW:0] occ; } st_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cam_lru_flush_if #(.key_width_p(KW), .val_width_p(VW), .camsize_p(N)) bus();
    cam_lru_flush #(.key_width_p(KW), .val_width_p(VW), .camsize_p(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    st_exp_t st_q[$];

    // Reference model: lru holds entry indices ordered MRU first.
    bit             m_v[N];
    logic [KW-1:0]  m_k[N];
    logic [VW-1:0]  m_d[N];
    int             lru[$];
    int             fl_left, fl_i, m_hits, m_evs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [KW-1:0] k);
        for (int i = 0; i < N; i++) if (m_v[i] && m_k[i] == k) return i;
        return -1;
    endfunction

    function automatic int occ();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic touch(input int e);
        for (int p = 0; p < lru.size(); p++)
            if (lru[p] == e) begin lru.delete(p); break; end
        lru.push_front(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_v[i] = 1'b0; m_k[i] = '0; m_d[i] = '0; end
        lru.delete();
        for (int i = 0; i < N; i++) lru.push_back(i);
        fl_left = 0; fl_i = 0; m_hits = 0; m_evs = 0;
    endtask

    // One clock: drive inputs, advance the model, then record the expected post-edge status.
    task automatic op(input bit wv, input logic [KW-1:0] wk, input logic [VW-1:0] wd,
                      input bit rv, input logic [KW-1:0] rk, input bit iv, input bit fl);
        int rh, wi;
        bit ev;
        logic [KW-1:0] ek;
        bus.w_v_i = wv; bus.w_key_i = wk; bus.w_data_i = wd;
        bus.r_v_i = rv; bus.r_key_i = rk; bus.inv_v_i = iv; bus.flush_i = fl;
        if (fl_left == 0) begin
            rh = find(rk);
            if (rv && rh >= 0) begin
                rd_q.push_back('{m_d[rh], IW'(rh)});
                m_hits++;
            end
            wi = -1; ev = 1'b0; ek = '0;
            if (wv) begin
                wi = find(wk);
                if (wi < 0)
                    for (int i = N - 1; i >= 0; i--) if (!m_v[i]) wi = i;
                if (wi < 0) begin
                    wi = lru[$]; ev = 1'b1; ek = m_k[wi]; m_evs++;
                end
                wr_q.push_back('{IW'(wi), ev, ek});
            end
            if (rv && rh >= 0) touch(rh);
            if (wv) touch(wi);
            if (iv && rh >= 0) m_v[rh] = 1'b0;
            if (wv) begin m_v[wi] = 1'b1; m_k[wi] = wk; m_d[wi] = wd; end
            if (fl) begin fl_left = N; fl_i = 0; end
        end else begin
            m_v[fl_i] = 1'b0;
            fl_i++;
            fl_left--;
            if (fl_left == 0) begin
                lru.delete();
                for (int i = 0; i < N; i++) lru.push_back(i);
            end
        end
        @(posedge clk);
        st_q.push_back('{fl_left == 0, (IW+1)'(occ())});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, '0, '0, 0, '0, 0, 0);
    endtask

    task automatic wr(input logic [KW-1:0] k, input logic [VW-1:0] d);
        op(1, k, d, 0, '0, 0, 0);
    endtask

    task automatic rdk(input logic [KW-1:0] k);
        op(0, '0, '0, 1, k, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus.w_v_i = 0; bus.r_v_i = 0; bus.inv_v_i = 0; bus.flush_i = 0;
        model_reset();
        #1;
        chk("reset_ready", bus.ready_o, 1);
        chk("reset_occupancy", bus.occupancy_o, 0);
        chk("reset_valid", bus.valid_o, 0);
        chk("reset_rdata", bus.rdata_o, 0);
        chk("reset_wdone", bus.wdone_o, 0);
        chk("reset_evict", bus.evict_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        st_exp_t s;
        rd_exp_t r;
        wr_exp_t w;
        if (mon_en) begin
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("ready", bus.ready_o, s.rdy);
                chk("occupancy", bus.occupancy_o, s.occ);
            end
            if (bus.valid_o) begin
                if (rd_q.size() == 0) chk("unexpected_read_hit", bus.valid_o, 0);
                else begin
                    r = rd_q.pop_front();
                    chk("rdata", bus.rdata_o, r.data);
                    chk("rindex", bus.rindex_o, r.idx);
                end
            end else chk("rdata_zero_on_miss", bus.rdata_o, 0);
            if (bus.wdone_o) begin
                if (wr_q.size() == 0) chk("unexpected_wdone", bus.wdone_o, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("windex", bus.windex_o, w.idx);
                    chk("evict", bus.evict_o, w.ev);
                    if (w.ev) chk("evict_key", bus.evict_key_o, w.ekey);
                end
            end
        end
    end

    initial begin
        bus.w_v_i = 0; bus.w_key_i = '0; bus.w_data_i = '0;
        bus.r_v_i = 0; bus.r_key_i = '0; bus.inv_v_i = 0; bus.flush_i = 0;
        model_reset();
        do_reset();

        rdk(8'h11);
        for (int i = 1; i <= 4; i++) wr(KW'(i), VW'(32'h9 + i));
        rdk(8'd1); wr(8'd5, 32'h50); wr(8'd6, 32'h60);
        wr(8'd3, 32'h55); rdk(8'd3);
        op(1, 8'd7, 32'h77, 1, 8'd7, 0, 0); rdk(8'd7);
        op(0, '0, '0, 0, 8'd7, 1, 0); wr(8'd9, 32'h99); rdk(8'd9);
        idle(1);

        // Full-CAM flush with a write issued alongside and writes during the flush.
        op(1, 8'd20, 32'h20, 1, 8'd9, 0, 1);
        for (int i = 0; i < N; i++) wr(8'd21, 32'h21);
        idle(2);
        wr(8'd9, 32'h1); rdk(8'd9);

        // Reset asserted during the second flush cycle.
        for (int i = 1; i <= 4; i++) wr(KW'(i), 32'hA0 + i);
        op(0, '0, '0, 0, '0, 0, 1);
        idle(1);
        do_reset();
        idle(1);

        for (int c = 0; c < 600; c++)
            op($urandom_range(0, 1), KW'($urandom_range(1, 6)), $urandom,
               $urandom_range(0, 1), KW'($urandom_range(1, 6)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
        idle(N + 2);
        @(negedge clk); #1;

        chk("read_queue_drained", rd_q.size(), 0);
        chk("write_queue_drained", wr_q.size(), 0);
`ifdef CAM_STATS_EN
        chk("hit_count", bus.hit_count_o, m_hits);
        chk("evict_count", bus.evict_count_o, m_evs);
`else
        chk("hit_count_tied", bus.hit_count_o, 0);
        chk("evict_count_tied", bus.evict_count_o, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
